// File: rtl/vga_output.sv
// VGA raster generator: h/v counters, delayed syncs and visible gating, frame-aligned game-over colour override.
// Outputs hsync/vsync/rgb lag the counters by PIXEL_LATENCY+1 clocks; free running, no backpressure.
module vga_output #(
    parameter int         H_VISIBLE      = 800,
    parameter int         H_FP           = 56,
    parameter int         H_SYNC         = 120,
    parameter int         H_BP           = 64,
    parameter int         V_VISIBLE      = 600,
    parameter int         V_FP           = 37,
    parameter int         V_SYNC         = 6,
    parameter int         V_BP           = 23,
    parameter bit         HSYNC_POL      = 1'b1,
    parameter bit         VSYNC_POL      = 1'b1,
    parameter int         PIXEL_LATENCY  = 1,
    parameter logic [5:0] GAMEOVER_COLOR = 6'b000011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  pixel_in,
    input  logic        game_over_in,
    input  logic        restart,
    output logic [10:0] cntr_h,
    output logic [9:0]  cntr_v,
    output logic        frame_tick,
    output logic        game_over,
    output logic        hsync,
    output logic        vsync,
    output logic [5:0]  rgb
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int D       = PIXEL_LATENCY + 1;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0]  VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [10:0] h_nxt;
    logic [9:0]  v_nxt;
    logic        h_wrap;
    logic        frame_end;
    logic        vis_raw;
    logic        hs_lvl;
    logic        vs_lvl;
    logic        vis_dly;
    logic        pending;
    logic        restart_req;
    logic [D-1:0] hs_q;
    logic [D-1:0] vs_q;

    always_comb begin
        h_wrap = (cntr_h == H_LAST);
        h_nxt  = h_wrap ? 11'd0 : cntr_h + 11'd1;
        v_nxt  = cntr_v;
        if (h_wrap) begin
            v_nxt = (cntr_v == V_LAST) ? 10'd0 : cntr_v + 10'd1;
        end
    end

    // frame_end looks at the next-state counters so it is high while they read (H_VISIBLE, V_VISIBLE)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cntr_h    <= '0;
            cntr_v    <= '0;
            frame_end <= 1'b0;
        end else begin
            cntr_h    <= h_nxt;
            cntr_v    <= v_nxt;
            frame_end <= (h_nxt == H_VIS) && (v_nxt == V_VIS);
        end
    end

    assign vis_raw = (cntr_h < H_VIS) && (cntr_v < V_VIS);
    assign hs_lvl  = ((cntr_h >= HS_START) && (cntr_h < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    assign vs_lvl  = ((cntr_v >= VS_START) && (cntr_v < VS_END)) ? VSYNC_POL : ~VSYNC_POL;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_q <= {D{~HSYNC_POL}};
            vs_q <= {D{~VSYNC_POL}};
        end else begin
            hs_q <= (hs_q << 1) | D'(hs_lvl);
            vs_q <= (vs_q << 1) | D'(vs_lvl);
        end
    end

    assign hsync = hs_q[D-1];
    assign vsync = vs_q[D-1];

    // visible only needs PIXEL_LATENCY stages: the rgb register supplies the last one
    generate
        if (PIXEL_LATENCY == 0) begin : g_vis_direct
            assign vis_dly = vis_raw;
        end else begin : g_vis_pipe
            logic [PIXEL_LATENCY-1:0] vis_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vis_q <= '0;
                end else begin
                    vis_q <= (vis_q << 1) | PIXEL_LATENCY'(vis_raw);
                end
            end
            assign vis_dly = vis_q[PIXEL_LATENCY-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb <= '0;
        end else if (!vis_dly) begin
            rgb <= '0;
        end else begin
            rgb <= game_over ? GAMEOVER_COLOR : pixel_in;
        end
    end

    // Requests collected during a frame resolve at frame_end; inputs seen on that cycle count for the next frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            game_over   <= 1'b0;
            pending     <= 1'b0;
            restart_req <= 1'b0;
        end else if (frame_end) begin
            if (restart_req) begin
                game_over <= 1'b0;
            end else if (pending) begin
                game_over <= 1'b1;
            end
            pending     <= game_over_in & ~game_over;
            restart_req <= restart;
        end else begin
            if (game_over_in && !game_over) begin
                pending <= 1'b1;
            end
            if (restart) begin
                restart_req <= 1'b1;
            end
        end
    end

    assign frame_tick = frame_end & ~game_over;

endmodule

// File: tb/tb_vga_output.sv
// Randomized bench for vga_output on a shrunken raster, checked against a position-arithmetic model.
module tb_vga_output;

    localparam int HV = 16, HF = 4, HS = 6, HB = 4;
    localparam int HT = HV + HF + HS + HB;
    localparam int VV = 10, VF = 2, VS = 2, VB = 3;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam logic [5:0] GO_COLOR = 6'b000011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  pixel_in = '0;
    logic        game_over_in = 1'b0;
    logic        restart = 1'b0;
    logic [10:0] cntr_h;
    logic [9:0]  cntr_v;
    logic        frame_tick;
    logic        game_over;
    logic        hsync;
    logic        vsync;
    logic [5:0]  rgb;

    vga_output #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIXEL_LATENCY(1),
        .GAMEOVER_COLOR(GO_COLOR)
    ) dut (
        .clk(clk), .rst(rst), .pixel_in(pixel_in), .game_over_in(game_over_in),
        .restart(restart), .cntr_h(cntr_h), .cntr_v(cntr_v), .frame_tick(frame_tick),
        .game_over(game_over), .hsync(hsync), .vsync(vsync), .rgb(rgb)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Reference model: n = clock edges since reset release; raster position is pure arithmetic on n
    int         n;
    bit         m_go, m_col, m_rr;
    logic       e_hs, e_vs;
    logic [5:0] e_rgb;

    function automatic bit vis_at(int k);
        return ((k % HT) < HV) && (((k / HT) % VT) < VV);
    endfunction

    function automatic bit hs_at(int k);
        return ((k % HT) >= HV + HF) && ((k % HT) < HV + HF + HS);
    endfunction

    function automatic bit vs_at(int k);
        return (((k / HT) % VT) >= VV + VF) && (((k / HT) % VT) < VV + VF + VS);
    endfunction

    function automatic bit fe_at(int k);
        return ((k % HT) == HV) && (((k / HT) % VT) == VV);
    endfunction

    function automatic bit at_pos(int h, int v);
        return ((n % HT) == h) && (((n / HT) % VT) == v);
    endfunction

    function automatic logic [30:0] exp_now();
        logic ft;
        ft = fe_at(n) && !m_go;
        return {11'(n % HT), 10'((n / HT) % VT), e_hs, e_vs, e_rgb, ft, logic'(m_go)};
    endfunction

    function automatic logic [30:0] dut_now();
        return {cntr_h, cntr_v, hsync, vsync, rgb, frame_tick, game_over};
    endfunction

    task automatic model_reset();
        n = 0; m_go = 0; m_col = 0; m_rr = 0;
        e_hs = 1'b0; e_vs = 1'b0; e_rgb = '0;
    endtask

    // Drive one cycle of inputs, advance one edge, update the model to the post-edge state
    task automatic tick(input logic [5:0] pix, input logic gi, input logic rs);
        bit old_go;
        pixel_in = pix; game_over_in = gi; restart = rs;
        @(posedge clk); #1;
        old_go = m_go;
        e_hs  = (n >= 1) && hs_at(n - 1);
        e_vs  = (n >= 1) && vs_at(n - 1);
        e_rgb = (n >= 1 && vis_at(n - 1)) ? (old_go ? GO_COLOR : pix) : 6'd0;
        if (fe_at(n)) begin
            if (m_rr) m_go = 0;
            else if (m_col) m_go = 1;
            m_col = gi && !old_go;
            m_rr  = rs;
        end else begin
            if (gi && !old_go) m_col = 1;
            if (rs) m_rr = 1;
        end
        n++;
        game_over_in = 1'b0; restart = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            pixel_in = 6'($urandom);
            game_over_in = 1'($urandom); restart = 1'($urandom);
            @(posedge clk); #1;
        end
        checks++; if (cntr_h !== 11'd0) begin fails++; $display("FAIL reset_cntr_h got=%0d exp=0", cntr_h); end
        checks++; if (cntr_v !== 10'd0) begin fails++; $display("FAIL reset_cntr_v got=%0d exp=0", cntr_v); end
        checks++; if (rgb !== 6'd0) begin fails++; $display("FAIL reset_rgb got=%b exp=000000", rgb); end
        checks++; if ({hsync, vsync} !== 2'b00) begin fails++; $display("FAIL reset_sync got=%b exp=00", {hsync, vsync}); end
        checks++; if ({frame_tick, game_over} !== 2'b00) begin fails++; $display("FAIL reset_tick_go got=%b exp=00", {frame_tick, game_over}); end
        game_over_in = 1'b0; restart = 1'b0;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_first_line();
        for (int i = 0; i < HT + 2; i++) begin
            tick(6'($urandom), 1'b0, 1'b0);
            checks++;
            if (dut_now() !== exp_now()) begin
                fails++; $display("FAIL first_line n=%0d dut=%h exp=%h", n, dut_now(), exp_now());
            end
            if (n <= 1) begin
                checks++;
                if ({rgb, hsync, vsync} !== 8'd0) begin
                    fails++; $display("FAIL first_blank n=%0d got=%b exp=0", n, {rgb, hsync, vsync});
                end
            end
            if (n == HT) begin
                checks++;
                if (cntr_h !== 11'd0 || cntr_v !== 10'd1) begin
                    fails++; $display("FAIL line_wrap got h=%0d v=%0d exp h=0 v=1", cntr_h, cntr_v);
                end
            end
        end
    endtask

    task automatic test_free_run();
        int ticks_seen, first_tick, last_tick, hs_cnt, vs_cnt;
        ticks_seen = 0; first_tick = -1; last_tick = -1; hs_cnt = 0; vs_cnt = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick(6'($urandom), 1'b0, 1'b0);
            checks++;
            if (dut_now() !== exp_now()) begin
                fails++; $display("FAIL free_run n=%0d dut=%h exp=%h", n, dut_now(), exp_now());
            end
            if (frame_tick === 1'b1) begin
                ticks_seen++;
                if (first_tick < 0) first_tick = n;
                last_tick = n;
            end
            if (hsync === 1'b1) hs_cnt++;
            if (vsync === 1'b1) vs_cnt++;
        end
        checks++; if (ticks_seen != 2) begin fails++; $display("FAIL tick_count got=%0d exp=2", ticks_seen); end
        checks++;
        if (last_tick - first_tick != FRAME) begin
            fails++; $display("FAIL tick_period got=%0d exp=%0d", last_tick - first_tick, FRAME);
        end
        checks++; if (hs_cnt != 2 * VT * HS) begin fails++; $display("FAIL hsync_width got=%0d exp=%0d", hs_cnt, 2 * VT * HS); end
        checks++; if (vs_cnt != 2 * VS * HT) begin fails++; $display("FAIL vsync_width got=%0d exp=%0d", vs_cnt, 2 * VS * HT); end
    endtask

    task automatic test_game_over();
        int guard;
        guard = 0;
        while (!at_pos(5, 3) && guard < 2 * FRAME) begin
            tick(6'b101010, 1'b0, 1'b0); guard++;
            checks++;
            if (dut_now() !== exp_now()) begin fails++; $display("FAIL go_pre n=%0d dut=%h exp=%h", n, dut_now(), exp_now()); end
        end
        tick(6'b101010, 1'b1, 1'b0);
        guard = 0;
        while (!fe_at(n) && guard < 2 * FRAME) begin
            tick(6'b101010, 1'b0, 1'b0); guard++;
            checks++;
            if (dut_now() !== exp_now()) begin fails++; $display("FAIL go_cur n=%0d dut=%h exp=%h", n, dut_now(), exp_now()); end
        end
        checks++;
        if (frame_tick !== 1'b1 || game_over !== 1'b0) begin
            fails++; $display("FAIL go_latch_frame got tick=%b go=%b exp tick=1 go=0", frame_tick, game_over);
        end
        for (int i = 0; i < FRAME + 1; i++) begin
            tick(6'b101010, 1'b0, 1'b0);
            checks++;
            if (dut_now() !== exp_now()) begin fails++; $display("FAIL go_next n=%0d dut=%h exp=%h", n, dut_now(), exp_now()); end
            if (i == 0 || fe_at(n)) begin
                checks++;
                if (game_over !== 1'b1 || frame_tick !== 1'b0) begin
                    fails++; $display("FAIL go_set n=%0d got go=%b tick=%b exp go=1 tick=0", n, game_over, frame_tick);
                end
            end
        end
    endtask

    task automatic test_restart();
        int guard;
        guard = 0;
        while (!at_pos(5, 5) && guard < 2 * FRAME) begin
            tick(6'($urandom), 1'b0, 1'b0); guard++;
        end
        tick(6'($urandom), 1'b0, 1'b1);
        for (int f = 0; f < 2; f++) begin
            guard = 0;
            do begin
                tick(6'($urandom), 1'b0, 1'b0); guard++;
                checks++;
                if (dut_now() !== exp_now()) begin fails++; $display("FAIL restart n=%0d dut=%h exp=%h", n, dut_now(), exp_now()); end
            end while (!fe_at(n) && guard < 2 * FRAME);
            checks++;
            if (frame_tick !== logic'(f == 1)) begin
                fails++; $display("FAIL restart_tick frame=%0d got=%b exp=%b", f, frame_tick, f == 1);
            end
        end
        tick(6'($urandom), 1'b0, 1'b0);
        checks++; if (game_over !== 1'b0) begin fails++; $display("FAIL restart_go got=%b exp=0", game_over); end
    endtask

    task automatic test_restart_and_collision();
        int guard;
        guard = 0;
        while (!at_pos(3, 2) && guard < 2 * FRAME) begin tick(6'($urandom), 1'b0, 1'b0); guard++; end
        tick(6'($urandom), 1'b1, 1'b0);
        guard = 0;
        while (!at_pos(7, 4) && guard < 2 * FRAME) begin tick(6'($urandom), 1'b0, 1'b0); guard++; end
        tick(6'($urandom), 1'b0, 1'b1);
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick(6'($urandom), 1'b0, 1'b0);
            checks++;
            if (dut_now() !== exp_now() || game_over !== 1'b0) begin
                fails++; $display("FAIL restart_wins n=%0d dut=%h exp=%h", n, dut_now(), exp_now());
            end
        end
    endtask

    task automatic test_random();
        logic gi, rs;
        for (int i = 0; i < 4 * FRAME; i++) begin
            gi = ($urandom_range(0, 299) == 0) && !fe_at(n);
            rs = ($urandom_range(0, 399) == 0) && !fe_at(n);
            tick(6'($urandom), gi, rs);
            checks++;
            if (dut_now() !== exp_now()) begin fails++; $display("FAIL random n=%0d dut=%h exp=%h", n, dut_now(), exp_now()); end
        end
    endtask

    task automatic test_reset_midframe();
        int guard;
        guard = 0;
        while (!at_pos(2, 1) && guard < 2 * FRAME) begin tick(6'($urandom), 1'b0, 1'b0); guard++; end
        tick(6'($urandom), 1'b1, 1'b0);
        guard = 0;
        while (!(at_pos(HV / 2, VV / 2) && m_go) && guard < 3 * FRAME) begin
            tick(6'($urandom), 1'b0, 1'b0); guard++;
        end
        checks++;
        if (dut_now() !== exp_now() || game_over !== 1'b1 || rgb !== GO_COLOR) begin
            fails++; $display("FAIL pre_reset n=%0d dut=%h exp=%h", n, dut_now(), exp_now());
        end
        rst = 1'b1;
        #1;
        checks++;
        if (dut_now() !== 31'd0) begin fails++; $display("FAIL async_clear dut=%h exp=0", dut_now()); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 2 * HT; i++) begin
            tick(6'($urandom), 1'b0, 1'b0);
            checks++;
            if (dut_now() !== exp_now()) begin fails++; $display("FAIL post_reset n=%0d dut=%h exp=%h", n, dut_now(), exp_now()); end
        end
    endtask

    initial begin
        test_reset();
        test_first_line();
        test_free_run();
        test_game_over();
        test_restart();
        test_restart_and_collision();
        test_random();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vga_output.md
VGA_OUTPUT -- requirements
Module: vga_output

Interface
REQ-001 SHALL have parameters H_VISIBLE=800, H_FP=56, H_SYNC=120, H_BP=64 (pixel clocks per line segment).
REQ-002 SHALL have parameters V_VISIBLE=600, V_FP=37, V_SYNC=6, V_BP=23 (lines per frame segment).
REQ-003 SHALL have parameters HSYNC_POL=1, VSYNC_POL=1 (active sync level), PIXEL_LATENCY=1 (pixel_in delay vs counters, legal 0..3), GAMEOVER_COLOR=6'b000011.
REQ-004 SHALL have ports: clk in 1, pixel clock, all logic on rising edge; rst in 1, asynchronous active-high reset.
REQ-005 SHALL have ports: pixel_in in 6, RRGGBB colour for the counters PIXEL_LATENCY cycles earlier; game_over_in in 1, collision indication (any cycle); restart in 1, restart request (pulse or level).
REQ-006 SHALL have ports: cntr_h out 11, horizontal counter; cntr_v out 10, vertical counter; frame_tick out 1, per-frame game-update strobe.
REQ-007 SHALL have ports: game_over out 1, latched game-over state; hsync out 1; vsync out 1; rgb out 6, final colour to DAC.

Function
REQ-008 cntr_h SHALL count 0..H_TOTAL-1 (H_TOTAL=H_VISIBLE+H_FP+H_SYNC+H_BP=1040), wrapping to 0.
REQ-009 cntr_v SHALL increment only in the cycle cntr_h wraps, counting 0..V_TOTAL-1 (V_TOTAL=666), wrapping to 0 when both counters wrap together.
REQ-010 visible SHALL be cntr_h<H_VISIBLE and cntr_v<V_VISIBLE.
REQ-011 raw hsync SHALL be active for cntr_h in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC) = [856,976), else inactive; active level = HSYNC_POL.
REQ-012 raw vsync SHALL be active for cntr_v in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC) = [637,643), whole lines; active level = VSYNC_POL.
REQ-013 visible, raw hsync, raw vsync SHALL be delayed PIXEL_LATENCY+1 cycles by a shift pipeline; hsync, vsync, rgb outputs are registered.
REQ-014 rgb SHALL equal 0 when delayed visible is 0; else GAMEOVER_COLOR when game_over=1; else pixel_in captured in the same register stage.
REQ-015 frame_end SHALL be an internal strobe high exactly in the cycle cntr_h==H_VISIBLE and cntr_v==V_VISIBLE (registered, derived from next-state counters so it aligns with them).
REQ-016 frame_tick SHALL equal frame_end while game_over=0 and SHALL stay 0 while game_over=1 (freezes objects).
REQ-017 Latch pending SHALL set on any cycle game_over_in=1 while game_over=0; latch restart_req SHALL set on any cycle restart=1.
REQ-018 On frame_end: if restart_req, game_over<=0 and pending, restart_req<=0; else if pending, game_over<=1 and pending<=0; else no change.
REQ-019 Simultaneous restart and game_over_in in one frame: restart wins; that frame's collisions are discarded.
REQ-020 game_over SHALL change only on frame_end, so rgb never switches colour source mid-frame.
REQ-021 game_over_in while game_over=1 SHALL be ignored.

Reset
REQ-022 While rst=1: cntr_h=0, cntr_v=0, frame_tick=0, game_over=0, rgb=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, all pipeline stages cleared to blank/inactive, pending=0, restart_req=0.
REQ-023 After rst deasserts mid-frame, counting SHALL resume from (0,0) on the first clock edge; no glitch pulse on hsync, vsync or frame_tick.

Verification
REQ-024 Reset, release, run 1040 cycles -> cntr_h 0..1039 then 0, cntr_v 0->1 on wrap; rgb=0, syncs inactive during first PIXEL_LATENCY+1 cycles.
REQ-025 Free run, defaults -> hsync high 120 cycles per 1040, starting 2 cycles after cntr_h==856; vsync high 6 lines starting at line 637 (+2 cycles).
REQ-026 Free run -> frame_tick pulses one cycle at (800,600), period 692640 cycles; no pulse anywhere else.
REQ-027 pixel_in=6'b101010 constant, game_over_in pulse at (100,100) -> rgb=101010 in visible area of current frame; from next frame visible rgb=000011, blank rgb=0, game_over=1 from frame_end onward, frame_tick suppressed.
REQ-028 With game_over=1, restart pulse at (5,5) -> game_over=0 at next frame_end, frame_tick resumes on following frame_end; restart plus game_over_in in same frame -> game_over stays 0.
REQ-029 rst asserted at (400,300) with game_over=1 -> immediate clear of all outputs per REQ-022; after release, normal raster from (0,0) and game_over=0.
